// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: shift-and-add multiplier controller (start/busy/done), one WA-bit add per clock.
// Optional SEQ_MULT_ZERO_SKIP_EN: zero operands finish in one cycle without entering CALC.
module seq_mult_ctrl #(
  parameter int WA = 5,
  parameter int WB = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [WA-1:0] in_a,
  input  logic [WB-1:0] in_b,
  output logic          busy,
  output logic          done,
  output logic [WA+WB-1:0] out_m
);
  localparam int CW = $clog2(WB + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, next;
  logic [WA-1:0] a_reg;
  logic [WA+WB-1:0] p, p_next;
  logic [CW-1:0] cnt;
  logic [WA:0] sum;
  logic last, zero, accept;
  always_comb begin
    sum = {1'b0, p[WA+WB-1:WB]} + {1'b0, (p[0] ? a_reg : {WA{1'b0}})};
    // carry lands in the top bit, multiplier bits shift out the bottom
    p_next = {sum, p[WB-1:1]};
    last = cnt == CW'(WB - 1);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    zero = (in_a == '0) || (in_b == '0);
`else
    zero = 1'b0;
`endif
    accept = (state == IDLE) && start;
    next = state == IDLE ? (start ? (zero ? DONE : CALC) : IDLE) :
           state == CALC ? (last ? DONE : CALC) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      a_reg <= '0;
      p <= '0;
      cnt <= '0;
      out_m <= '0;
    end else if (accept) begin
      a_reg <= in_a;
      p <= {{WA{1'b0}}, in_b};
      cnt <= '0;
      if (zero) out_m <= '0;
    end else if (state == CALC) begin
      p <= p_next;
      cnt <= cnt + CW'(1);
      if (last) out_m <= p_next;
    end
  assign busy = state == CALC;
  assign done = state == DONE;
endmodule
